vga_timing: RTL

VGA_TIMING -- requirements
Module: vga_timing

---
 rtl/vga_timing_if.sv | 24 ++
 rtl/vga_timing.sv | 125 ++++++++++++
 2 files changed

// File: rtl/vga_timing_if.sv
// Video timing bus: enable in, sync/data-enable/coordinates/prefetch out.
interface vga_timing_if;
    logic       enable;
    logic       hsync;
    logic       vsync;
    logic       de;
    logic [9:0] x;
    logic [9:0] y;
    logic       frame_start;
    logic       fetch_req;
    logic [9:0] fetch_line;

    // Timing generator side
    modport master (
        input  enable,
        output hsync, vsync, de, x, y, frame_start, fetch_req, fetch_line
    );

    // Pixel pipeline side
    modport slave (
        output enable,
        input  hsync, vsync, de, x, y, frame_start, fetch_req, fetch_line
    );
endinterface

// File: rtl/vga_timing.sv
// VGA raster timing generator: h/v counters, registered syncs, data enable,
// visible coordinates, frame-start pulse and one-line-ahead prefetch request.
module vga_timing #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter bit          SYNC_POL  = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    vga_timing_if.master bus
);

    localparam int unsigned HT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned VT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] HtLast = 10'(HT - 1);
    localparam logic [9:0] VtLast = 10'(VT - 1);
    localparam logic [9:0] HVis   = 10'(H_VISIBLE);
    localparam logic [9:0] VVis   = 10'(V_VISIBLE);
    localparam logic [9:0] HsBeg  = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HsEnd  = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VsBeg  = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VsEnd  = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       de_q, de_d;
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       frame_start_q, frame_start_d;
    logic       fetch_req_q, fetch_req_d;
    logic [9:0] fetch_line_q, fetch_line_d;

    logic [9:0] next_line;
    logic       visible;

    // Counter advance with line and frame wrap in the same cycle
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (bus.enable) begin
            if (h_cnt_q == HtLast) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == VtLast) ? '0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
    end

    // Output decode from current counters; registered so outputs lag by one cycle
    always_comb begin
        next_line     = (v_cnt_q == VtLast) ? '0 : v_cnt_q + 10'd1;
        visible       = (h_cnt_q < HVis) && (v_cnt_q < VVis);
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        de_d          = 1'b0;
        x_d           = '0;
        y_d           = '0;
        frame_start_d = 1'b0;
        fetch_req_d   = 1'b0;
        fetch_line_d  = fetch_line_q;
        if (bus.enable) begin
            hsync_d = ((h_cnt_q >= HsBeg) && (h_cnt_q < HsEnd)) ? SYNC_POL : ~SYNC_POL;
            // vsync depends only on v_cnt, so it flips exactly at h_cnt=0
            vsync_d = ((v_cnt_q >= VsBeg) && (v_cnt_q < VsEnd)) ? SYNC_POL : ~SYNC_POL;
            de_d    = visible;
            if (visible) begin
                x_d = h_cnt_q;
                y_d = v_cnt_q;
            end
            frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
            // Request the following line once the visible part of this one ends
            if ((h_cnt_q == HVis) && (next_line < VVis)) begin
                fetch_req_d  = 1'b1;
                fetch_line_d = next_line;
            end
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            de_q          <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            frame_start_q <= 1'b0;
            fetch_req_q   <= 1'b0;
            fetch_line_q  <= '0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            x_q           <= x_d;
            y_q           <= y_d;
            frame_start_q <= frame_start_d;
            fetch_req_q   <= fetch_req_d;
            fetch_line_q  <= fetch_line_d;
        end
    end

    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.de          = de_q;
    assign bus.x           = x_q;
    assign bus.y           = y_q;
    assign bus.frame_start = frame_start_q;
    assign bus.fetch_req   = fetch_req_q;
    assign bus.fetch_line  = fetch_line_q;

endmodule
